// File: rtl/alu_mult_sequencer.sv
// Multi-cycle unsigned multiply (MULTU) controller. It borrows the shared
// execute-stage ALU for a shift-add loop of WIDTH iterations and produces a
// 2*WIDTH-bit {hi,lo} product. While busy, the CPU stalls and routes the ALU
// operands from this block whenever alu_sel is high.
module alu_mult_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             alu_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [5:0]       alu_opcode,
   output logic [5:0]       alu_funct,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_carryout
);

   localparam logic [5:0] RTYPE_OP  = 6'b000000;
   localparam logic [5:0] ADD_FUNCT = 6'b100000;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] mreg;
   logic [WIDTH:0]   acc;

   // Partial sum for this iteration: the ALU's hi+mreg (with carry) when the
   // current multiplier bit is set, otherwise the unchanged hi word.
   assign acc = lo[0] ? {alu_carryout, alu_res} : {1'b0, hi};

   // State register.
   // NOTE: every clocked process uses non-blocking assignments so all
   // registers update together from the values present before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode; start is honoured only in IDLE, DONE always returns.
   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (count == LAST_ITER) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture operands on acceptance, then shift the 33-bit partial
   // sum right through {hi,lo} once per CALC cycle. Outside CALC the product
   // words hold, so hi/lo stay valid until the next accepted start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         mreg  <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mreg  <= op_a;
                  hi    <= '0;
                  lo    <= op_b;
                  count <= '0;
               end
            end
            CALC: begin
               hi    <= acc[WIDTH:1];
               lo    <= {acc[0], lo[WIDTH-1:1]};
               count <= count + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Moore status outputs and the ALU operand/control feed.
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign alu_sel    = (state == CALC);
   assign alu_a      = hi;
   assign alu_b      = mreg;
   assign alu_opcode = RTYPE_OP;
   assign alu_funct  = ADD_FUNCT;

endmodule
